// File: rtl/writeback_unit_if.sv
// Bundles the producer handshake, the register-file write port and the
// hazard/status outputs of the writeback unit.
interface writeback_unit_if #(
    parameter int CNTW = 16
);
    logic            valid_in;
    logic            ready_in;
    logic            RegWrite_in;
    logic            MemtoReg_in;
    logic [4:0]      rd_in;
    logic [63:0]     alu_result;
    logic [63:0]     mem_data;
    logic            wb_stall;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            ExtRegWrite;
    logic [4:0]      WriteReg;
    logic [63:0]     WriteData;
    logic            hazard1;
    logic            hazard2;
    logic [CNTW-1:0] wb_count;

    // Producer / decode side: drives results and read addresses, observes writes.
    modport master (
        output valid_in, RegWrite_in, MemtoReg_in, rd_in, alu_result, mem_data,
        output wb_stall, rs1, rs2,
        input  ready_in, ExtRegWrite, WriteReg, WriteData, hazard1, hazard2, wb_count
    );

    // The writeback unit itself.
    modport slave (
        input  valid_in, RegWrite_in, MemtoReg_in, rd_in, alu_result, mem_data,
        input  wb_stall, rs1, rs2,
        output ready_in, ExtRegWrite, WriteReg, WriteData, hazard1, hazard2, wb_count
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: buffers completed results in a small circular FIFO and
// drains at most one register-file write per cycle, skipping x0 and
// non-writing results, flagging RAW hazards for decode and counting commits.
module writeback_unit #(
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    writeback_unit_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_ext_we;
    logic [4:0]      r_wreg;
    logic [63:0]     r_wdata;
    logic [CNTW-1:0] r_wb_count;

    logic            w_ready;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    entry_t          w_push_entry;
    logic            w_hz1;
    logic            w_hz2;
    logic [AW-1:0]   w_idx;

    // Handshake, x0/no-write filter and the accept-time data mux.
    assign w_ready      = (r_count < FULL_CNT);
    assign w_accept     = bus.valid_in && w_ready;
    assign w_push       = w_accept && bus.RegWrite_in && (bus.rd_in != 5'd0);
    assign w_pop        = (r_count != '0) && !bus.wb_stall;
    assign w_push_entry = '{rd:   bus.rd_in,
                            data: bus.MemtoReg_in ? bus.mem_data : bus.alu_result};

    // Hazard search over the live FIFO entries plus the write in flight this cycle.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment,
        // otherwise the unassigned paths would infer latches.
        w_hz1 = 1'b0;
        w_hz2 = 1'b0;
        w_idx = r_rptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + AW'(i);
            if (CW'(i) < r_count) begin
                if (r_mem[w_idx].rd == bus.rs1) w_hz1 = 1'b1;
                if (r_mem[w_idx].rd == bus.rs2) w_hz2 = 1'b1;
            end
        end
        if (r_ext_we && (r_wreg == bus.rs1)) w_hz1 = 1'b1;
        if (r_ext_we && (r_wreg == bus.rs2)) w_hz2 = 1'b1;
        if (bus.rs1 == 5'd0) w_hz1 = 1'b0;
        if (bus.rs2 == 5'd0) w_hz2 = 1'b0;
    end

    // FIFO storage write; contents are only meaningful under the occupancy count.
    // NOTE: the storage array has no reset -- the pointers and count define
    // validity, so resetting the data would only cost flops.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_push_entry;
    end

    // Pointers, occupancy, output register and commit counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ext_we   <= 1'b0;
            r_wreg     <= 5'd0;
            r_wdata    <= 64'd0;
            r_wb_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_ext_we <= w_pop;
            if (w_pop) begin
                r_wreg  <= r_mem[r_rptr].rd;
                r_wdata <= r_mem[r_rptr].data;
            end
            if (r_ext_we) r_wb_count <= r_wb_count + 1'b1;
        end
    end

    assign bus.ready_in    = w_ready;
    assign bus.ExtRegWrite = r_ext_we;
    assign bus.WriteReg    = r_wreg;
    assign bus.WriteData   = r_wdata;
    assign bus.hazard1     = w_hz1;
    assign bus.hazard2     = w_hz2;
    assign bus.wb_count    = r_wb_count;
endmodule
